// File: rtl/output_pipeline.sv
// -----------------------------------------------------------------------------
// output_pipeline
//   Final stage of the histogram equalizer. Reads the original image back from
//   m3 as 128-bit words of 16 x 8-bit pixels. Maps each pixel through the
//   equalization LUT in scratchpad m2. Repacks the mapped pixels and writes each
//   completed word to the output memory m4.
//
//   Optional feature macro: OUTPUT_TAG_CHECK_EN
//     When it is defined, a LUT entry whose tag m2ReadBus[35:20] differs from
//     LUT_TAG maps its pixel to 8'h00 and sets the sticky tag_error flag.
//     When it is undefined, m2ReadBus[7:0] is used as-is and tag_error is tied 0.
//
// Ports
//   clock            system clock; all state changes on the rising edge
//   rst_n            asynchronous active-low reset
//   start            level enable; low returns to idle and clears all state
//   outputBaseOffset frame buffer select, the MSB of the m3 and m4 addresses
//   m3ReadAddr       {outputBaseOffset, wordCnt}; combinational
//   m3ReadBus        image word, valid one cycle after its address
//   m2ReadAddr       {8'h00, current pixel}; combinational
//   m2ReadBus        LUT entry: [35:20] tag, [7:0] mapped value; 1-cycle latency
//   m4WriteAddr      address of the completed word; registered
//   m4WriteBus       packed mapped word; registered
//   m4WE             one-cycle write strobe
//   output_done      registered; high once the last word has been written
//   tag_error        sticky LUT tag mismatch flag
// -----------------------------------------------------------------------------
module output_pipeline #(
  parameter logic [14:0] ADDRESS_OF_LAST = 15'd3,
  parameter logic [15:0] LUT_TAG         = 16'hAAAA
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         outputBaseOffset,
  output logic [15:0]  m3ReadAddr,
  input  logic [127:0] m3ReadBus,
  output logic [15:0]  m2ReadAddr,
  input  logic [35:0]  m2ReadBus,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteBus,
  output logic         m4WE,
  output logic         output_done,
  output logic         tag_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_MAP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        state;
  logic [14:0]   wordCnt;
  logic [3:0]    lane;
  logic [127:0]  wordReg;
  logic [127:0]  packReg;
  logic [3:0]    laneD;
  logic          validD;
  logic [14:0]   wordD;      // word index that belongs to the returning LUT data
  logic          drainCnt;
  logic [7:0]    mapped;

  assign m3ReadAddr = {outputBaseOffset, wordCnt};
  assign m2ReadAddr = {8'h00, wordReg[8*lane +: 8]};

`ifdef OUTPUT_TAG_CHECK_EN
  logic tag_ok;
  assign tag_ok = (m2ReadBus[35:20] == LUT_TAG);

  always_comb begin
    mapped = m2ReadBus[7:0];
    if (!tag_ok) mapped = '0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      tag_error <= 1'b0;
    else if (!start)
      tag_error <= 1'b0;
    else if (validD && !tag_ok)
      tag_error <= 1'b1;
  end
`else
  logic unused_tag;
  assign unused_tag = ^{m2ReadBus[35:8], LUT_TAG};
  assign mapped     = m2ReadBus[7:0];
  assign tag_error  = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wordCnt     <= '0;
      lane        <= '0;
      wordReg     <= '0;
      packReg     <= '0;
      laneD       <= '0;
      validD      <= 1'b0;
      wordD       <= '0;
      drainCnt    <= 1'b0;
      m4WE        <= 1'b0;
      m4WriteAddr <= '0;
      m4WriteBus  <= '0;
      output_done <= 1'b0;
    end else if (!start) begin
      state       <= ST_IDLE;
      wordCnt     <= '0;
      lane        <= '0;
      wordReg     <= '0;
      packReg     <= '0;
      laneD       <= '0;
      validD      <= 1'b0;
      wordD       <= '0;
      drainCnt    <= 1'b0;
      m4WE        <= 1'b0;
      m4WriteAddr <= '0;
      m4WriteBus  <= '0;
      output_done <= 1'b0;
    end else begin
      m4WE   <= 1'b0;
      // Lane, valid and word index trail the LUT address by one cycle so they
      // line up with the data coming back on m2ReadBus.
      validD <= (state == ST_MAP);
      laneD  <= lane;
      wordD  <= wordCnt;

      if (validD) begin
        packReg[8*laneD +: 8] <= mapped;
        // Lane 15 merges straight from the bus. The next word's FETCH/WAIT runs
        // in parallel, so wordD rather than wordCnt gives the write address.
        if (laneD == 4'd15) begin
          m4WriteBus  <= {mapped, packReg[119:0]};
          m4WriteAddr <= {outputBaseOffset, wordD};
          m4WE        <= 1'b1;
        end
      end

      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          wordReg <= m3ReadBus;
          lane    <= '0;
          state   <= ST_MAP;
        end
        ST_MAP: begin
          lane <= lane + 4'd1;
          if (lane == 4'd15) begin
            if (wordCnt == ADDRESS_OF_LAST) begin
              drainCnt <= 1'b0;
              state    <= ST_DRAIN;
            end else begin
              wordCnt <= wordCnt + 15'd1;
              state   <= ST_FETCH;
            end
          end
        end
        ST_DRAIN: begin
          drainCnt <= 1'b1;
          if (drainCnt) begin
            output_done <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE:  output_done <= 1'b1;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_pipeline.sv
// -----------------------------------------------------------------------------
// tb_output_pipeline
//   Directed bench for output_pipeline. It uses behavioural m3 and m2 memories
//   with a one-cycle synchronous read, hand-computed expected words, and one
//   checking task.
// -----------------------------------------------------------------------------
module tb_output_pipeline;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic         outputBaseOffset;
  logic [15:0]  m3ReadAddr;
  logic [127:0] m3ReadBus;
  logic [15:0]  m2ReadAddr;
  logic [35:0]  m2ReadBus;
  logic [15:0]  m4WriteAddr;
  logic [127:0] m4WriteBus;
  logic         m4WE;
  logic         output_done;
  logic         tag_error;

  output_pipeline #(
    .ADDRESS_OF_LAST (15'd3),
    .LUT_TAG         (16'hAAAA)
  ) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .start            (start),
    .outputBaseOffset (outputBaseOffset),
    .m3ReadAddr       (m3ReadAddr),
    .m3ReadBus        (m3ReadBus),
    .m2ReadAddr       (m2ReadAddr),
    .m2ReadBus        (m2ReadBus),
    .m4WriteAddr      (m4WriteAddr),
    .m4WriteBus       (m4WriteBus),
    .m4WE             (m4WE),
    .output_done      (output_done),
    .tag_error        (tag_error)
  );

  always #5 clock = ~clock;

  int unsigned  cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory models. Reads from outside the selected 4-word frame return poison,
  // so a wrong m3 address shows up as bad data.
  logic [127:0] m3mem [4];
  logic [35:0]  lut   [256];
  logic         curOff;

  always @(posedge clock) begin
    if (m3ReadAddr[15] == curOff && m3ReadAddr[14:2] == 13'h0)
      m3ReadBus <= m3mem[m3ReadAddr[1:0]];
    else
      m3ReadBus <= {4{32'hDEADBEEF}};
    m2ReadBus <= lut[m2ReadAddr[7:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Results collected by run_frame
  int           nwr;
  int           wrCyc  [4];
  logic [15:0]  wrAddr [4];
  logic [127:0] wrData [4];
  int           doneCyc;
  logic [15:0]  fetchAddr0;
  logic         tagErrAt5;
  logic         tagErrAt10;

  // Raises start, then watches ncyc cycles. dropAt and rstAt, when not
  // negative, give the relative cycle at which start is dropped or rst_n is
  // pulsed.
  task automatic run_frame(input logic off, input int ncyc, input int dropAt, input int rstAt);
    int s;
    int rel;
    nwr = 0; doneCyc = -1; fetchAddr0 = '1; tagErrAt5 = 1'bx; tagErrAt10 = 1'bx;
    @(negedge clock);
    curOff = off;
    outputBaseOffset = off;
    start = 1'b1;
    s = int'(cyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      rel = int'(cyc) - s;
      if (rel == 1) fetchAddr0 = m3ReadAddr;
      if (rel == 5) tagErrAt5 = tag_error;
      if (rel == 10) tagErrAt10 = tag_error;
      if (m4WE) begin
        if (nwr < 4) begin
          wrCyc[nwr] = rel; wrAddr[nwr] = m4WriteAddr; wrData[nwr] = m4WriteBus;
        end
        nwr++;
      end
      if (output_done && doneCyc < 0) doneCyc = rel;
      if (rel == dropAt) start = 1'b0;
      if (rel == rstAt) begin
        rst_n = 1'b0;
        #1;
        check("async rst m4WE", {127'h0, m4WE}, '0);
        check("async rst done", {127'h0, output_done}, '0);
        check("async rst bus", m4WriteBus, '0);
        #2 rst_n = 1'b1;
      end
    end
  endtask

  task automatic stop_run();
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic load_lut(input int kind);
    for (int p = 0; p < 256; p++) begin
      if (kind == 0) lut[p] = {16'hAAAA, 12'h0, 8'(p)};
      else           lut[p] = {16'hAAAA, 12'h0, 8'(255 - p)};
    end
  endtask

  logic [127:0] exp;
  logic [7:0]   b;

  initial begin
    rst_n = 1'b0; start = 1'b0; outputBaseOffset = 1'b0; curOff = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 16; k++)
        m3mem[w][8*k +: 8] = 8'(16*w + k);
    load_lut(0);
    repeat (3) @(negedge clock);
    check("reset m4WE", {127'h0, m4WE}, '0);
    check("reset m4WriteAddr", {112'h0, m4WriteAddr}, '0);
    check("reset m4WriteBus", m4WriteBus, '0);
    check("reset output_done", {127'h0, output_done}, '0);
    check("reset tag_error", {127'h0, tag_error}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1: identity LUT, timing and pass-through data
    run_frame(1'b0, 80, -1, -1);
    check("t1 write count", nwr, 4);
    check("t1 fetch addr", {112'h0, fetchAddr0}, 128'h0);
    for (int n = 0; n < 4; n++) begin
      check($sformatf("t1 wr%0d cycle", n), wrCyc[n], 20 + 18*n);
      check($sformatf("t1 wr%0d addr", n), {112'h0, wrAddr[n]}, n);
      check($sformatf("t1 wr%0d data", n), wrData[n], m3mem[n]);
    end
    check("t1 done cycle", doneCyc, 75);
    check("t1 done held", {127'h0, output_done}, 128'h1);
    stop_run();
    check("t1 done cleared", {127'h0, output_done}, '0);

    // 2: inverting LUT, lane order
    load_lut(1);
    run_frame(1'b0, 80, -1, -1);
    check("t2 wr0 data", wrData[0], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    exp = wrData[0];
    check("t2 byte0", {120'h0, exp[7:0]}, 128'hFF);
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = 8'(255 - (16*3 + k));
    check("t2 wr3 data", wrData[3], exp);
    stop_run();

    // 3: frame buffer select
    load_lut(0);
    run_frame(1'b1, 80, -1, -1);
    check("t3 write count", nwr, 4);
    check("t3 fetch addr", {112'h0, fetchAddr0}, 128'h8000);
    for (int n = 0; n < 4; n++) begin
      check($sformatf("t3 wr%0d addr", n), {112'h0, wrAddr[n]}, 128'h8000 + n);
      check($sformatf("t3 wr%0d data", n), wrData[n], m3mem[n]);
    end
    stop_run();

    // 4: bad tag on the entry for pixel 0x05
    lut[5] = {16'h0000, 12'h0, 8'h05};
    run_frame(1'b0, 80, -1, -1);
    exp = m3mem[0];
`ifdef OUTPUT_TAG_CHECK_EN
    exp[47:40] = 8'h00;
    check("t4 tag_error before", {127'h0, tagErrAt5}, '0);
    check("t4 tag_error rise", {127'h0, tagErrAt10}, 128'h1);
    check("t4 tag_error sticky", {127'h0, tag_error}, 128'h1);
`else
    check("t4 tag_error tied", {127'h0, tagErrAt10}, '0);
    check("t4 tag_error end", {127'h0, tag_error}, '0);
`endif
    check("t4 wr0 data", wrData[0], exp);
    check("t4 wr1 data", wrData[1], m3mem[1]);
    stop_run();
    check("t4 tag_error cleared", {127'h0, tag_error}, '0);
    load_lut(0);

    // 5: start dropped during MAP of word 0, then restart
    run_frame(1'b0, 40, 10, -1);
    check("t5 no write", nwr, 0);
    check("t5 no done", {127'h0, output_done}, '0);
    run_frame(1'b0, 25, -1, -1);
    check("t5 restart fetch", {112'h0, fetchAddr0}, 128'h0);
    check("t5 restart wr0 cycle", wrCyc[0], 20);
    check("t5 restart wr0 data", wrData[0], m3mem[0]);
    stop_run();

    // 6: reset pulse just before the first write
    run_frame(1'b0, 30, -1, 19);
    check("t6 no write", nwr, 0);
    stop_run();

    b = 8'h0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
